instruction_fetch_unit: RTL and testbench

- Sequences the 256x16 instruction ROM (8-bit address, 16-bit combinational read data) for the processor front end.
- Owns the program counter and drives the ROM address.
- Captures each instruction word with its PC into a small prefetch buffer and hands it to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing stale prefetched words.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, halt word, FSM state and prefetch entry types for instruction fetch
//
// Purpose : common definitions imported by fetch_fifo and instruction_fetch_unit.
// Contents: ADDR_W_DEF / DATA_W_DEF  default PC and instruction widths
//           HALT_WORD                instruction word that halts fetch (FETCH_HALT_ON_ZERO_EN builds)
//           fetch_state_t            IDLE / RUN / HALTED
//           fetch_entry_t            one prefetched word with its address
package fetch_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   localparam logic [DATA_W_DEF-1:0] HALT_WORD = 16'h0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [DATA_W_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous prefetch FIFO of fetch_entry_t with flush
//
// Purpose : holds fetched {pc, instr} words between the ROM and decode.
// Ports   : clk, reset        clock, asynchronous active-high reset
//           push, push_entry  write one entry (dropped when full without a pop)
//           pop               remove the head entry (ignored when empty)
//           flush             empty the FIFO; overrides push and pop
//           head_entry        current head entry (stale when count is zero)
//           count             number of stored entries, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head_entry,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            // DEPTH is a power of two, so pointers wrap naturally
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
         end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencing, ROM fetch and prefetch handshake to decode
//
// Purpose : owns the PC, walks the instruction ROM into a prefetch FIFO, hands words to
//           decode over valid/ready, and takes branch redirects from execute.
// Config  : FETCH_HALT_ON_ZERO_EN - when defined, fetching HALT_WORD stops fetch (HALTED).
// Ports   : clk, reset                  clock, asynchronous active-high reset
//           start                       pulse: IDLE/HALTED -> RUN
//           rom_addr / rom_data         ROM address (= PC) and combinational read data
//           if_valid/if_ready           decode handshake
//           if_instr/if_pc              head instruction and its address
//           redirect_valid/redirect_pc  taken branch/jump and its target
//           halted                      high while in HALTED
//           fetch_count                 saturating count of delivered instructions
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       fetch_count_q, fetch_count_d;

   logic [CNT_W-1:0]  buf_count;
   fetch_entry_t      head_entry;
   fetch_entry_t      push_entry;
   logic              pop;
   logic              fifo_pop;
   logic              fetch_ok;
   logic              halt_hit;
   logic              push;

   assign if_valid = (buf_count != '0);
   assign pop      = if_valid & if_ready;

   always_comb begin
      // A redirect wins over everything: the handshake that cycle is discarded
      fifo_pop = pop & ~redirect_valid;
      // A slot is free if the FIFO is not full or the head leaves this same edge
      fetch_ok = (state_q == RUN) & ~redirect_valid & ((buf_count < FULL_CNT) | pop);
`ifdef FETCH_HALT_ON_ZERO_EN
      halt_hit = fetch_ok & (rom_data == HALT_WORD);
`else
      halt_hit = 1'b0;
`endif
      push             = fetch_ok & ~halt_hit;
      push_entry.pc    = pc_q;
      push_entry.instr = rom_data;

      pc_d          = pc_q;
      state_d       = state_q;
      fetch_count_d = fetch_count_q;

      if (redirect_valid) begin
         pc_d    = redirect_pc;
         state_d = RUN;
      end else begin
         if (push) begin
            pc_d = pc_q + ADDR_W'(1);
         end
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt_hit) state_d = HALTED;
            HALTED:  if (start) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end

      if (fifo_pop && (fetch_count_q != 16'hFFFF)) begin
         fetch_count_d = fetch_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .flush      (redirect_valid),
      .head_entry (head_entry),
      .count      (buf_count)
   );

   assign rom_addr    = pc_q;
   assign if_instr    = head_entry.instr;
   assign if_pc       = head_entry.pc;
   assign fetch_count = fetch_count_q;
`ifdef FETCH_HALT_ON_ZERO_EN
   assign halted      = (state_q == HALTED);
`else
   assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   localparam int DEPTH = 2;
`ifdef FETCH_HALT_ON_ZERO_EN
   localparam bit HALT_FEAT = 1'b1;
`else
   localparam bit HALT_FEAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        if_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic [7:0]  rom_addr;
   logic [7:0]  if_pc;
   logic [15:0] rom_data;
   logic [15:0] if_instr;
   logic [15:0] fetch_count;
   logic        if_valid;
   logic        halted;

   logic [15:0] rom [256];
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .ADDR_W   (8),
      .DATA_W   (16),
      .DEPTH    (DEPTH),
      .RESET_PC (8'h00)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   // Reference model: a queue of delivered-but-not-consumed words plus PC/mode/count
   typedef struct {
      logic [7:0]  pc;
      logic [15:0] instr;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] m_pc;
   int         m_mode;   // 0 idle, 1 run, 2 halted
   int         m_cnt;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 8'h00;
      m_mode = 0;
      m_cnt  = 0;
   endtask

   task automatic check_model(input string ph);
      logic has;
      has = (mq.size() > 0);
      chk({ph, ":if_valid"}, 32'(if_valid), 32'(has));
      if (has) begin
         chk({ph, ":if_pc"}, 32'(if_pc), 32'(mq[0].pc));
         chk({ph, ":if_instr"}, 32'(if_instr), 32'(mq[0].instr));
      end
      chk({ph, ":rom_addr"}, 32'(rom_addr), 32'(m_pc));
      chk({ph, ":fetch_count"}, 32'(fetch_count), 32'(m_cnt));
      chk({ph, ":halted"}, 32'(halted), 32'(m_mode == 2));
   endtask

   // Drive one cycle of inputs, check current outputs, advance model and clock
   task automatic step(input logic st, input logic rdy, input logic rv,
                       input logic [7:0] rpc, input string ph);
      int   pre;
      logic pop_m;
      logic slot;
      ent_t e;
      start          = st;
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      check_model(ph);
      pre = m_mode;
      if (rv) begin
         mq.delete();
         m_pc   = rpc;
         m_mode = 1;
      end else begin
         pop_m = (mq.size() > 0) && rdy;
         slot  = (pre == 1) && ((mq.size() < DEPTH) || pop_m);
         if (pop_m) begin
            mq.delete(0);
            if (m_cnt < 65535) m_cnt++;
         end
         if (slot) begin
            if (HALT_FEAT && rom[m_pc] == 16'h0000) begin
               m_mode = 2;
            end else begin
               e.pc    = m_pc;
               e.instr = rom[m_pc];
               mq.push_back(e);
               m_pc = m_pc + 8'd1;
            end
         end
         if (st && pre != 1) m_mode = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      if_ready = 1'b0;
      redirect_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[0] = 16'h4864; rom[1] = 16'h4A0A; rom[2] = 16'h4C50; rom[3] = 16'h4F96;
      rom[4] = 16'h0880; rom[5] = 16'h5614; rom[6] = 16'h6180; rom[7] = 16'h6848;
      rom[8] = 16'h8820; rom[9] = 16'h4F94;

      // Reset state
      model_reset();
      @(posedge clk);
      #1;
      chk("rst:if_valid", 32'(if_valid), 32'h0);
      chk("rst:rom_addr", 32'(rom_addr), 32'h00);
      chk("rst:if_instr", 32'(if_instr), 32'h0);
      chk("rst:if_pc", 32'(if_pc), 32'h0);
      chk("rst:halted", 32'(halted), 32'h0);
      chk("rst:fetch_count", 32'(fetch_count), 32'h0);
      reset = 1'b0;

      // Streaming program with decode always ready
      step(1'b1, 1'b1, 1'b0, 8'h00, "seq");
      repeat (11) step(1'b0, 1'b1, 1'b0, 8'h00, "seq");
      chk("seq:count10", 32'(fetch_count), 32'd10);

      // Backpressure: buffer fills, PC holds
      do_reset();
      step(1'b1, 1'b0, 1'b0, 8'h00, "bp");
      repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, "bp");
      chk("bp:rom_addr_hold", 32'(rom_addr), 32'h02);
      chk("bp:head_pc", 32'(if_pc), 32'h00);
      chk("bp:head_instr", 32'(if_instr), 32'h4864);
      repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, "bp_drain");
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, "bp_fill");

      // Redirect with full buffer (and a pop offered that must be ignored)
      step(1'b0, 1'b1, 1'b1, 8'h05, "redir");
      chk("redir:flushed", 32'(if_valid), 32'h0);
      step(1'b0, 1'b1, 1'b0, 8'h00, "redir");
      chk("redir:first_pc", 32'(if_pc), 32'h05);
      chk("redir:first_instr", 32'(if_instr), 32'h5614);
      repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, "redir");

`ifndef FETCH_HALT_ON_ZERO_EN
      // PC wrap at FF
      step(1'b0, 1'b1, 1'b1, 8'hFF, "wrap");
      step(1'b0, 1'b1, 1'b0, 8'h00, "wrap");
      chk("wrap:pc_ff", 32'(if_pc), 32'hFF);
      chk("wrap:instr_ff", 32'(if_instr), 32'h0000);
      step(1'b0, 1'b1, 1'b0, 8'h00, "wrap");
      chk("wrap:pc_00", 32'(if_pc), 32'h00);
      chk("wrap:instr_00", 32'(if_instr), 32'h4864);
      chk("wrap:halted", 32'(halted), 32'h0);
`else
      // Halt on zero word, then resume via redirect
      do_reset();
      step(1'b1, 1'b1, 1'b0, 8'h00, "halt");
      repeat (14) step(1'b0, 1'b1, 1'b0, 8'h00, "halt");
      chk("halt:halted", 32'(halted), 32'h1);
      chk("halt:if_valid", 32'(if_valid), 32'h0);
      chk("halt:rom_addr", 32'(rom_addr), 32'h0A);
      step(1'b0, 1'b1, 1'b1, 8'h03, "halt_redir");
      chk("halt_redir:halted", 32'(halted), 32'h0);
      step(1'b0, 1'b1, 1'b0, 8'h00, "halt_redir");
      chk("halt_redir:pc", 32'(if_pc), 32'h03);
      chk("halt_redir:instr", 32'(if_instr), 32'h4F96);
`endif

      // Asynchronous reset between edges
      do_reset();
      step(1'b1, 1'b1, 1'b0, 8'h00, "arst");
      repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00, "arst");
      #3;
      reset = 1'b1;
      #1;
      chk("arst:if_valid", 32'(if_valid), 32'h0);
      chk("arst:rom_addr", 32'(rom_addr), 32'h00);
      chk("arst:fetch_count", 32'(fetch_count), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 8'h00, "arst_restart");
      step(1'b0, 1'b1, 1'b0, 8'h00, "arst_restart");
      chk("arst:restart_pc", 32'(if_pc), 32'h00);
      chk("arst:restart_instr", 32'(if_instr), 32'h4864);
      repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, "arst_restart");

      // Randomized traffic against the model
      do_reset();
      step(1'b1, 1'b1, 1'b0, 8'h00, "rand");
      for (int k = 0; k < 400; k++) begin
         logic       r_rv, r_rdy, r_st;
         logic [7:0] r_pc;
         r_rv  = ($urandom_range(0, 99) < 6);
         r_rdy = ($urandom_range(0, 99) < 65);
         r_st  = ($urandom_range(0, 99) < 5);
         r_pc  = ($urandom_range(0, 9) == 0) ? 8'hFE : 8'($urandom_range(0, 11));
         step(r_st, r_rdy, r_rv, r_pc, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
